// File: rtl/dtcm_arb_if.sv
// Bus bundle between the CPU memory stage, the external requester and the DTCM.
// The arbiter takes the slave view; the requesters and the DTCM take the master view.
interface dtcm_arb_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic              cpu_en;
  logic [BE_W-1:0]   cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ext_req;
  logic [BE_W-1:0]   ext_wen;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_lock;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic              dtcm_en;
  logic [BE_W-1:0]   dtcm_wen;
  logic [ADDR_W-1:0] dtcm_addr;
  logic [DATA_W-1:0] dtcm_wdata;
  logic [DATA_W-1:0] dtcm_rdata;

  modport slave (
    input  cpu_en, cpu_wen, cpu_addr, cpu_wdata,
    input  ext_req, ext_wen, ext_addr, ext_wdata, ext_lock,
    input  dtcm_rdata,
    output cpu_rdata, cpu_stall,
    output ext_gnt, ext_rvalid, ext_rdata,
    output dtcm_en, dtcm_wen, dtcm_addr, dtcm_wdata
  );

  modport master (
    output cpu_en, cpu_wen, cpu_addr, cpu_wdata,
    output ext_req, ext_wen, ext_addr, ext_wdata, ext_lock,
    output dtcm_rdata,
    input  cpu_rdata, cpu_stall,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  dtcm_en, dtcm_wen, dtcm_addr, dtcm_wdata
  );
endinterface

// File: rtl/dtcm_arb.sv
// Two-port arbiter sharing the single-ported DTCM between the CPU and an external
// requester: CPU priority by default, starvation escape and lockable EXT bursts.
module dtcm_arb #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 4
) (
  input logic        clk,
  input logic        reset,
  dtcm_arb_if.slave  bus
);

  typedef enum logic {
    CPU_PRI = 1'b0,
    EXT_PRI = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_e           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             ext_rd_q;
  logic             cpu_rd_q;

  logic             starved_c;
  logic             ext_win_c;
  logic             cpu_go_c;

  // Same-cycle grant; reset masks every grant so nothing reaches the DTCM.
  always_comb begin
    starved_c = (starve_cnt == CNT_MAX);
    ext_win_c = bus.ext_req & ~reset &
                (~bus.cpu_en | (state == EXT_PRI) | starved_c);
    cpu_go_c  = bus.cpu_en & ~reset & ~ext_win_c;
  end

  assign bus.ext_gnt   = ext_win_c;
  assign bus.cpu_stall = bus.cpu_en & ext_win_c;

  // DTCM request mux; idle address/data follow the CPU to avoid extra muxing.
  always_comb begin
    bus.dtcm_en    = 1'b0;
    bus.dtcm_wen   = '0;
    bus.dtcm_addr  = bus.cpu_addr;
    bus.dtcm_wdata = bus.cpu_wdata;
    if (ext_win_c) begin
      bus.dtcm_en    = 1'b1;
      bus.dtcm_wen   = bus.ext_wen;
      bus.dtcm_addr  = bus.ext_addr;
      bus.dtcm_wdata = bus.ext_wdata;
    end else if (cpu_go_c) begin
      bus.dtcm_en    = 1'b1;
      bus.dtcm_wen   = bus.cpu_wen;
    end
  end

  // Priority state, starvation counter and read-return flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CPU_PRI;
      starve_cnt <= '0;
      ext_rd_q   <= 1'b0;
      cpu_rd_q   <= 1'b0;
    end else begin
      case (state)
        CPU_PRI: if (ext_win_c & bus.ext_lock) state <= EXT_PRI;
        EXT_PRI: if ((ext_win_c & ~bus.ext_lock) | ~bus.ext_req) state <= CPU_PRI;
      endcase

      if (ext_win_c | ~bus.ext_req) begin
        starve_cnt <= '0;
      end else if (!starved_c) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end

      ext_rd_q <= ext_win_c & (bus.ext_wen == '0);
      cpu_rd_q <= cpu_go_c & (bus.cpu_wen == '0);
    end
  end

  // Read data straight from the DTCM; a reset in the return cycle drops the valid.
  assign bus.ext_rvalid = ext_rd_q & ~reset;
  assign bus.ext_rdata  = bus.dtcm_rdata;
  assign bus.cpu_rdata  = cpu_rd_q ? bus.dtcm_rdata : '0;

endmodule

// File: tb/tb_dtcm_arb.sv
// Bench for dtcm_arb: reset-relative vector table, directed multi-cycle sequences
// and a randomized run against a transaction-level arbitration/memory model.
module tb_dtcm_arb;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned N_RAND     = 2000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dtcm_arb_if bus();

  dtcm_arb #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Behavioural DTCM: one-cycle read latency, byte-enabled writes, reloaded on reset.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (bus.dtcm_en) begin
      if (bus.dtcm_wen == 4'h0) bus.dtcm_rdata <= mem[bus.dtcm_addr[9:2]];
      else mem[bus.dtcm_addr[9:2]] <= merge(mem[bus.dtcm_addr[9:2]], bus.dtcm_wdata, bus.dtcm_wen);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic ce, input logic [3:0] cw, input logic [31:0] ca,
                     input logic [31:0] cd, input logic er, input logic [3:0] ew,
                     input logic [31:0] ea, input logic [31:0] ed, input logic el);
    bus.cpu_en = ce; bus.cpu_wen = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.ext_req = er; bus.ext_wen = ew; bus.ext_addr = ea; bus.ext_wdata = ed;
    bus.ext_lock = el;
  endtask

  task automatic idle();
    drv(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic chk_hs(input string name, input logic gnt, input logic stall, input logic en);
    chk({name, ".ext_gnt"},   32'(bus.ext_gnt),   32'(gnt));
    chk({name, ".cpu_stall"}, 32'(bus.cpu_stall), 32'(stall));
    chk({name, ".dtcm_en"},   32'(bus.dtcm_en),   32'(en));
  endtask

  typedef struct {
    string       name;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic        ext_req;
    logic [3:0]  ext_wen;
    logic [31:0] ext_addr;
    logic        ext_lock;
    logic        e_gnt;
    logic        e_stall;
    logic        e_en;
    logic [3:0]  e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic rs, input logic ce, input logic [3:0] cw,
                              input logic [31:0] ca, input logic er, input logic [3:0] ew,
                              input logic [31:0] ea, input logic el, input logic g, input logic s,
                              input logic en, input logic [3:0] w, input logic [31:0] a,
                              input logic [31:0] d);
    vec_t v;
    v.name = nm; v.rst = rs; v.cpu_en = ce; v.cpu_wen = cw; v.cpu_addr = ca;
    v.ext_req = er; v.ext_wen = ew; v.ext_addr = ea; v.ext_lock = el;
    v.e_gnt = g; v.e_stall = s; v.e_en = en; v.e_wen = w; v.e_addr = a; v.e_wdata = d;
    return v;
  endfunction

  // Fixed write-data patterns derived from the address so the table stays compact.
  function automatic logic [31:0] cpu_d(input logic [31:0] a);
    return 32'hC0C0_0000 ^ a;
  endfunction
  function automatic logic [31:0] ext_d(input logic [31:0] a);
    return 32'hE0E0_0000 ^ a;
  endfunction

  vec_t vecs [9];

  // Random-phase model state.
  int          waited;
  bit          burst;
  bit          prev_ext_rd, prev_cpu_rd;
  logic [31:0] exp_ext_d, exp_cpu_d;
  logic [31:0] shadow [256];
  bit          hold_cpu, hold_ext;
  bit          rst_now, e_gnt, cpu_ok;

  initial begin
    reset = 1'b1;
    idle();
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // Single-cycle vectors, each applied from a fresh reset (CPU_PRI, counter 0).
    vecs[0] = mk("idle",        0, 0, 4'h0, 32'h0,   0, 4'h0, 32'h0,  0, 0, 0, 0, 4'h0, 32'h0,   32'h0);
    vecs[1] = mk("cpu_rd",      0, 1, 4'h0, 32'h100, 0, 4'h0, 32'h0,  0, 0, 0, 1, 4'h0, 32'h100, cpu_d(32'h100));
    vecs[2] = mk("cpu_wr",      0, 1, 4'h3, 32'h204, 0, 4'h0, 32'h0,  0, 0, 0, 1, 4'h3, 32'h204, cpu_d(32'h204));
    vecs[3] = mk("ext_wr",      0, 0, 4'h0, 32'h0,   1, 4'hF, 32'h40, 0, 1, 0, 1, 4'hF, 32'h40,  ext_d(32'h40));
    vecs[4] = mk("ext_rd",      0, 0, 4'h0, 32'h0,   1, 4'h0, 32'h80, 0, 1, 0, 1, 4'h0, 32'h80,  ext_d(32'h80));
    vecs[5] = mk("both_cpu",    0, 1, 4'h0, 32'h10,  1, 4'hF, 32'h20, 0, 0, 0, 1, 4'h0, 32'h10,  cpu_d(32'h10));
    vecs[6] = mk("both_lock",   0, 1, 4'h5, 32'h14,  1, 4'h0, 32'h24, 1, 0, 0, 1, 4'h5, 32'h14,  cpu_d(32'h14));
    vecs[7] = mk("rst_both",    1, 1, 4'hF, 32'h18,  1, 4'hF, 32'h28, 1, 0, 0, 0, 4'h0, 32'h0,   32'h0);
    vecs[8] = mk("rst_ext",     1, 0, 4'h0, 32'h0,   1, 4'hF, 32'h2C, 0, 0, 0, 0, 4'h0, 32'h0,   32'h0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      drv(vecs[i].cpu_en, vecs[i].cpu_wen, vecs[i].cpu_addr, cpu_d(vecs[i].cpu_addr),
          vecs[i].ext_req, vecs[i].ext_wen, vecs[i].ext_addr, ext_d(vecs[i].ext_addr),
          vecs[i].ext_lock);
      reset = vecs[i].rst;
      @(negedge clk);
      chk_hs(vecs[i].name, vecs[i].e_gnt, vecs[i].e_stall, vecs[i].e_en);
      chk({vecs[i].name, ".dtcm_wen"}, 32'(bus.dtcm_wen), 32'(vecs[i].e_wen));
      chk({vecs[i].name, ".ext_rvalid"}, 32'(bus.ext_rvalid), 32'h0);
      if (vecs[i].e_en) begin
        chk({vecs[i].name, ".dtcm_addr"},  bus.dtcm_addr,  vecs[i].e_addr);
        chk({vecs[i].name, ".dtcm_wdata"}, bus.dtcm_wdata, vecs[i].e_wdata);
      end
      next_cycle();
      reset = 1'b0;
    end

    // CPU write then read-back of 0x100.
    do_reset();
    drv(1, 4'hF, 32'h100, 32'hDEAD_BEEF, 0, 4'h0, 32'h0, 32'h0, 0);
    @(negedge clk); chk_hs("cpu_wr100", 0, 0, 1);
    next_cycle();
    drv(1, 4'h0, 32'h100, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    @(negedge clk); chk_hs("cpu_rd100", 0, 0, 1);
    next_cycle();
    idle();
    @(negedge clk); chk("cpu_rdata100", bus.cpu_rdata, 32'hDEAD_BEEF);
    chk("idle_en", 32'(bus.dtcm_en), 32'h0);
    next_cycle();

    // EXT write then read-back of 0x40.
    drv(0, 4'h0, 32'h0, 32'h0, 1, 4'hF, 32'h40, 32'h1234_5678, 0);
    @(negedge clk); chk_hs("ext_wr40", 1, 0, 1); chk("ext_wr40.wen", 32'(bus.dtcm_wen), 32'hF);
    next_cycle();
    drv(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h40, 32'h0, 0);
    @(negedge clk); chk_hs("ext_rd40", 1, 0, 1); chk("ext_wr40.rvalid", 32'(bus.ext_rvalid), 32'h0);
    next_cycle();
    idle();
    @(negedge clk); chk("ext_rd40.rvalid", 32'(bus.ext_rvalid), 32'h1);
    chk("ext_rd40.rdata", bus.ext_rdata, 32'h1234_5678);
    next_cycle();

    // Starvation: both held, CPU wins STARVE_MAX times, then EXT once.
    do_reset();
    drv(1, 4'h0, 32'h8, 32'h0, 1, 4'h0, 32'h40, 32'h0, 0);
    for (int c = 0; c < int'(STARVE_MAX); c++) begin
      @(negedge clk); chk_hs($sformatf("starve_c%0d", c), 0, 0, 1);
      chk($sformatf("starve_c%0d.addr", c), bus.dtcm_addr, 32'h8);
      next_cycle();
    end
    @(negedge clk); chk_hs("starve_win", 1, 1, 1); chk("starve_win.addr", bus.dtcm_addr, 32'h40);
    next_cycle();
    drv(1, 4'h0, 32'h8, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    @(negedge clk); chk_hs("starve_after", 0, 0, 1);
    chk("starve_after.rvalid", 32'(bus.ext_rvalid), 32'h1);
    chk("starve_after.rdata", bus.ext_rdata, init_word(16));
    next_cycle();
    drv(1, 4'h0, 32'h8, 32'h0, 1, 4'h0, 32'h44, 32'h0, 0);
    @(negedge clk); chk_hs("starve_restart", 0, 0, 1);
    next_cycle();

    // Locked burst of three EXT reads against a continuous CPU request.
    do_reset();
    drv(1, 4'h0, 32'hC, 32'h0, 1, 4'h0, 32'h80, 32'h0, 1);
    for (int c = 0; c < int'(STARVE_MAX); c++) begin
      @(negedge clk); chk_hs($sformatf("lock_pre%0d", c), 0, 0, 1);
      next_cycle();
    end
    @(negedge clk); chk_hs("lock_b0", 1, 1, 1);
    next_cycle();
    drv(1, 4'h0, 32'hC, 32'h0, 1, 4'h0, 32'h84, 32'h0, 1);
    @(negedge clk); chk_hs("lock_b1", 1, 1, 1); chk("lock_b1.rdata", bus.ext_rdata, init_word(32));
    next_cycle();
    drv(1, 4'h0, 32'hC, 32'h0, 1, 4'h0, 32'h88, 32'h0, 0);
    @(negedge clk); chk_hs("lock_b2", 1, 1, 1); chk("lock_b2.rdata", bus.ext_rdata, init_word(33));
    next_cycle();
    drv(1, 4'h0, 32'hC, 32'h0, 1, 4'h0, 32'h8C, 32'h0, 0);
    @(negedge clk); chk_hs("lock_end", 0, 0, 1); chk("lock_end.rdata", bus.ext_rdata, init_word(34));
    chk("lock_end.rvalid", 32'(bus.ext_rvalid), 32'h1);
    next_cycle();

    // Reset the cycle after a locked EXT read grant.
    do_reset();
    drv(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h40, 32'h0, 1);
    @(negedge clk); chk_hs("rstrd_gnt", 1, 0, 1);
    next_cycle();
    drv(1, 4'hF, 32'h4, 32'h0, 1, 4'hF, 32'h40, 32'h0, 1);
    reset = 1'b1;
    @(negedge clk); chk_hs("rstrd_in", 0, 0, 0);
    chk("rstrd_in.rvalid", 32'(bus.ext_rvalid), 32'h0);
    chk("rstrd_in.wen", 32'(bus.dtcm_wen), 32'h0);
    next_cycle();
    reset = 1'b0;
    drv(1, 4'h0, 32'h4, 32'h0, 1, 4'h0, 32'h40, 32'h0, 0);
    for (int c = 0; c < int'(STARVE_MAX); c++) begin
      @(negedge clk); chk_hs($sformatf("rstrd_post%0d", c), 0, 0, 1);
      next_cycle();
    end
    @(negedge clk); chk_hs("rstrd_win", 1, 1, 1);
    next_cycle();

    // Idle after the burst settles.
    idle();
    next_cycle();
    @(negedge clk); chk_hs("idle", 0, 0, 0);
    chk("idle.wen", 32'(bus.dtcm_wen), 32'h0);
    chk("idle.rvalid", 32'(bus.ext_rvalid), 32'h0);
    next_cycle();

    // Randomized traffic against the transaction model.
    do_reset();
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    waited = 0; burst = 0; prev_ext_rd = 0; prev_cpu_rd = 0;
    hold_cpu = 0; hold_ext = 0;
    for (int k = 0; k < int'(N_RAND); k++) begin
      rst_now = ($urandom_range(0, 79) == 0);
      if (!hold_cpu) begin
        bus.cpu_en    = ($urandom_range(0, 2) != 0);
        bus.cpu_wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        bus.cpu_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        bus.cpu_wdata = $urandom;
      end
      if (!hold_ext) begin
        bus.ext_req   = ($urandom_range(0, 1) == 1);
        bus.ext_wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        bus.ext_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        bus.ext_wdata = $urandom;
      end
      bus.ext_lock = ($urandom_range(0, 2) == 0);
      reset = rst_now;
      @(negedge clk);

      e_gnt  = !rst_now && bus.ext_req &&
               (!bus.cpu_en || burst || waited >= int'(STARVE_MAX));
      cpu_ok = !rst_now && bus.cpu_en && !e_gnt;
      chk_hs("rand", e_gnt, bus.cpu_en && e_gnt, e_gnt || cpu_ok);
      chk("rand.rvalid", 32'(bus.ext_rvalid), 32'(prev_ext_rd && !rst_now));
      if (prev_ext_rd && !rst_now) chk("rand.ext_rdata", bus.ext_rdata, exp_ext_d);
      if (prev_cpu_rd && !rst_now) chk("rand.cpu_rdata", bus.cpu_rdata, exp_cpu_d);
      if (e_gnt) begin
        chk("rand.wen_e", 32'(bus.dtcm_wen), 32'(bus.ext_wen));
        chk("rand.addr_e", bus.dtcm_addr, bus.ext_addr);
        if (bus.ext_wen != 4'h0) chk("rand.wdata_e", bus.dtcm_wdata, bus.ext_wdata);
      end else if (cpu_ok) begin
        chk("rand.wen_c", 32'(bus.dtcm_wen), 32'(bus.cpu_wen));
        chk("rand.addr_c", bus.dtcm_addr, bus.cpu_addr);
        if (bus.cpu_wen != 4'h0) chk("rand.wdata_c", bus.dtcm_wdata, bus.cpu_wdata);
      end else begin
        chk("rand.wen_0", 32'(bus.dtcm_wen), 32'h0);
      end

      prev_ext_rd = 0;
      prev_cpu_rd = 0;
      if (rst_now) begin
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        waited = 0;
        burst  = 0;
      end else begin
        if (e_gnt) begin
          if (bus.ext_wen == 4'h0) begin
            prev_ext_rd = 1; exp_ext_d = shadow[bus.ext_addr[9:2]];
          end else begin
            shadow[bus.ext_addr[9:2]] = merge(shadow[bus.ext_addr[9:2]], bus.ext_wdata, bus.ext_wen);
          end
        end else if (cpu_ok) begin
          if (bus.cpu_wen == 4'h0) begin
            prev_cpu_rd = 1; exp_cpu_d = shadow[bus.cpu_addr[9:2]];
          end else begin
            shadow[bus.cpu_addr[9:2]] = merge(shadow[bus.cpu_addr[9:2]], bus.cpu_wdata, bus.cpu_wen);
          end
        end
        if (e_gnt) burst = bus.ext_lock;
        else if (!bus.ext_req) burst = 0;
        if (e_gnt || !bus.ext_req) waited = 0;
        else if (waited < int'(STARVE_MAX)) waited++;
      end
      hold_cpu = bus.cpu_en && !cpu_ok;
      hold_ext = bus.ext_req && !e_gnt;
      next_cycle();
    end
    reset = 1'b0;
    idle();
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dtcm_arb.md
Name: dtcm_arb

Overview:
Two-port arbiter in front of the single-ported DTCM. It shares the DTCM between the core's memory-access stage (CPU port) and an external requester (debug loader/DMA, EXT port).
- CPU has default priority.
- EXT is protected from starvation by a counter, and can lock the DTCM for back-to-back bursts.
- Read data returns one cycle after grant, matching DTCM latency.

Parameters:
STARVE_MAX, 4, consecutive blocked EXT cycles after which EXT wins over CPU (1..15)
CNT_W, 4, width of the starvation counter; must hold STARVE_MAX

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_en  in  1  CPU access request this cycle
cpu_wen  in  4  CPU byte write enables (0 = read)
cpu_addr  in  32  CPU byte address
cpu_wdata  in  32  CPU write data (already lane-replicated)
cpu_rdata  out  32  CPU read data, cycle after accepted read
cpu_stall  out  1  CPU access not accepted this cycle; CPU holds request
ext_req  in  1  EXT access request; held until ext_gnt
ext_wen  in  4  EXT byte write enables (0 = read)
ext_addr  in  32  EXT byte address
ext_wdata  in  32  EXT write data
ext_lock  in  1  keep EXT priority for the next access (burst)
ext_gnt  out  1  EXT access accepted this cycle
ext_rvalid  out  1  ext_rdata valid
ext_rdata  out  32  EXT read data
dtcm_en  out  1  DTCM enable
dtcm_wen  out  4  DTCM byte write enables
dtcm_addr  out  32  DTCM byte address
dtcm_wdata  out  32  DTCM write data
dtcm_rdata  in  32  DTCM read data, one cycle after dtcm_en

Behaviour:
- State machine, 1-bit, registered:
  - CPU_PRI: CPU wins a conflict unless starve_cnt == STARVE_MAX.
  - EXT_PRI: EXT wins any conflict.
- Grant, combinational in the same cycle:
  - ext_win = ext_req & (~cpu_en | state==EXT_PRI | starve_cnt==STARVE_MAX).
  - ext_gnt = ext_win.
  - cpu_stall = cpu_en & ext_win.
- DTCM mux:
  - If ext_win: drive ext_* onto dtcm_*.
  - Else if cpu_en: drive cpu_*.
  - Else: dtcm_en=0, dtcm_wen=0, addr/wdata don't-care.
  - dtcm_en = ext_win | cpu_en.
- Transitions:
  - CPU_PRI -> EXT_PRI on ext_gnt & ext_lock.
  - EXT_PRI -> CPU_PRI on (ext_gnt & ~ext_lock) or ~ext_req.
  - Otherwise hold.
- starve_cnt:
  - Cleared on ext_gnt or ~ext_req.
  - Incremented when ext_req & ~ext_gnt.
  - Saturates at STARVE_MAX.
- Read return:
  - Registers ext_rd_q = ext_gnt & (ext_wen==0) and cpu_rd_q = cpu_en & ~cpu_stall & (cpu_wen==0).
  - ext_rvalid = ext_rd_q; ext_rdata = dtcm_rdata.
  - cpu_rdata = dtcm_rdata; meaningful only the cycle after cpu_rd_q was set. Lane alignment is done by the CPU side.
- Latency: grant 0 cycles, read data 1 cycle, write commits at grant edge.
- Simultaneous events:
  - CPU and EXT both requesting: CPU_PRI with counter below max -> CPU granted, counter +1.
  - EXT grant with ext_lock=1 and a CPU request next cycle -> EXT wins again.
- Reset, synchronous, while reset=1:
  - state=CPU_PRI, starve_cnt=0, ext_rd_q=0, cpu_rd_q=0.
  - Combinational outputs forced: dtcm_en=0, dtcm_wen=0, ext_gnt=0, cpu_stall=0, ext_rvalid=0.
  - Reset asserted the cycle after a read grant drops that ext_rvalid; no write occurs during reset.
- A request held across a stall must keep address/data stable; the arbiter does not latch request payloads.

Test Plan:
- CPU only: cpu_en=1, cpu_wen=0, addr 0x100, DTCM returns 0xDEADBEEF -> dtcm_en=1, cpu_stall=0, cpu_rdata=0xDEADBEEF next cycle.
- EXT only: ext_req=1, ext_wen=0xF, addr 0x40, data 0x12345678 -> ext_gnt=1 same cycle, dtcm_wen=0xF, no ext_rvalid; subsequent EXT read of 0x40 gives ext_rvalid=1, ext_rdata=0x12345678 one cycle after grant.
- Starvation with STARVE_MAX=4, cpu_en and ext_req held high from cycle 0:
  - cycles 0-3: CPU granted, starve_cnt 1..4.
  - cycle 4: ext_gnt=1, cpu_stall=1.
  - cycle 5: CPU granted, counter 0.
- Lock burst: ext_lock=1 for 3 EXT reads with cpu_en=1 throughout -> three consecutive ext_gnt, cpu_stall=1 for all three. ext_lock=0 on the third -> CPU granted the following cycle.
- Reset mid-read: EXT read granted at cycle N, reset=1 at N+1 -> ext_rvalid=0 at N+1, state CPU_PRI, starve_cnt=0 after release.
- Idle: no requests -> dtcm_en=0, dtcm_wen=0, all handshake outputs 0.
